ram_fifo_ctrl: RTL and testbench

- FIFO controller that uses an external ram_dualport instance as storage: port A is the write side, port B the read side.
- Sits between a byte producer (e.g. UART/SPI RX or a host loading a TX buffer) and its consumer.
- Presents a push/full interface upstream and a first-word-fall-through valid/pop interface downstream.
- Hides the RAM's 1-cycle registered read latency behind a 2-entry output buffer; sustains 1 word/cycle.

---
 rtl/ram_fifo_ctrl_if.sv | 38 +++
 rtl/ram_fifo_ctrl.sv | 131 +++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of the FIFO controller's handshake and RAM-port signals.
//   in_push/in_data/out_full/out_overflow   : upstream push side
//   out_valid/out_data/in_pop/out_underflow : downstream FWFT pop side
//   out_level                               : total words held
//   out_ram_*/in_ram_data_b                 : connection to the dual-port RAM
// Modport slave is used by the controller; master by whatever drives it.
interface ram_fifo_ctrl_if #(
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned RAM_DATA_WIDTH = 8
);
  logic                      in_push;
  logic [RAM_DATA_WIDTH-1:0] in_data;
  logic                      out_full;
  logic                      out_overflow;
  logic                      out_valid;
  logic [RAM_DATA_WIDTH-1:0] out_data;
  logic                      in_pop;
  logic                      out_underflow;
  logic [RAM_ADDR_WIDTH+1:0] out_level;
  logic [RAM_ADDR_WIDTH-1:0] out_ram_addr_a;
  logic [RAM_DATA_WIDTH-1:0] out_ram_data_a;
  logic                      out_ram_wr_a;
  logic [RAM_ADDR_WIDTH-1:0] out_ram_addr_b;
  logic                      out_ram_wr_b;
  logic [RAM_DATA_WIDTH-1:0] in_ram_data_b;

  modport slave (
    input  in_push, in_data, in_pop, in_ram_data_b,
    output out_full, out_overflow, out_valid, out_data, out_underflow, out_level,
           out_ram_addr_a, out_ram_data_a, out_ram_wr_a, out_ram_addr_b, out_ram_wr_b
  );

  modport master (
    output in_push, in_data, in_pop, in_ram_data_b,
    input  out_full, out_overflow, out_valid, out_data, out_underflow, out_level,
           out_ram_addr_a, out_ram_data_a, out_ram_wr_a, out_ram_addr_b, out_ram_wr_b
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller using an external dual-port RAM as storage (port A writes,
// port B reads with one cycle of registered latency). A head/skid output
// buffer hides the read latency and gives a first-word-fall-through interface
// that sustains one word per cycle.
// Ports:
//   in_clk, in_rst : clock, asynchronous active-high reset
//   bus            : ram_fifo_ctrl_if.slave (push/pop handshakes, level, RAM ports)
module ram_fifo_ctrl #(
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned RAM_DATA_WIDTH = 8
) (
  input logic            in_clk,
  input logic            in_rst,
  ram_fifo_ctrl_if.slave bus
);
  localparam int unsigned LevelW = RAM_ADDR_WIDTH + 2;
  localparam int unsigned CountW = RAM_ADDR_WIDTH + 1;
  localparam logic [RAM_ADDR_WIDTH:0] Depth = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};

  logic [RAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [RAM_ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic [LevelW-1:0]         level_q, level_d;
  logic                      inflight_q, inflight_d;
  logic                      head_v_q, head_v_d;
  logic                      skid_v_q, skid_v_d;
  logic [RAM_DATA_WIDTH-1:0] head_q, head_d;
  logic [RAM_DATA_WIDTH-1:0] skid_q, skid_d;
  logic                      overflow_q, overflow_d;
  logic                      underflow_q, underflow_d;

  logic       full;
  logic       push_acc;
  logic       pop_acc;
  logic       issue;
  logic [1:0] held;

  assign full     = (ram_count_q == Depth);
  assign push_acc = bus.in_push & ~full;
  assign pop_acc  = bus.in_pop & head_v_q;

  // Words already past the RAM: output buffer plus the read in flight.
  assign held  = 2'(head_v_q) + 2'(skid_v_q) + 2'(inflight_q);
  // ram_count excludes this cycle's write, so port B never races port A.
  assign issue = (ram_count_q != '0) && ((held - 2'(pop_acc)) < 2'd2);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q + CountW'(push_acc) - CountW'(issue);
    level_d     = level_q + LevelW'(push_acc) - LevelW'(pop_acc);
    inflight_d  = issue;
    head_v_d    = head_v_q;
    skid_v_d    = skid_v_q;
    head_d      = head_q;
    skid_d      = skid_q;
    overflow_d  = bus.in_push & full;
    underflow_d = bus.in_pop & ~head_v_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (pop_acc) begin
      if (skid_v_q) begin
        head_d = skid_q;
        if (inflight_q) begin
          skid_d = bus.in_ram_data_b;
        end else begin
          skid_v_d = 1'b0;
        end
      end else if (inflight_q) begin
        head_d = bus.in_ram_data_b;
      end else begin
        // Head data is kept; only the valid flag drops.
        head_v_d = 1'b0;
      end
    end else if (inflight_q) begin
      if (!head_v_q) begin
        head_d   = bus.in_ram_data_b;
        head_v_d = 1'b1;
      end else begin
        skid_d   = bus.in_ram_data_b;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      level_q     <= '0;
      inflight_q  <= 1'b0;
      head_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      head_v_q    <= head_v_d;
      skid_v_q    <= skid_v_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.out_full       = full;
  assign bus.out_overflow   = overflow_q;
  assign bus.out_underflow  = underflow_q;
  assign bus.out_valid      = head_v_q;
  assign bus.out_data       = head_q;
  assign bus.out_level      = level_q;
  assign bus.out_ram_addr_a = wr_ptr_q;
  assign bus.out_ram_data_a = bus.in_data;
  assign bus.out_ram_wr_a   = push_acc & ~in_rst;
  assign bus.out_ram_addr_b = rd_ptr_q;
  assign bus.out_ram_wr_b   = 1'b0;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a 4-deep RAM: directed vector table, hand
// sequences for wrap/throughput and mid-stream reset, then random traffic
// checked against a queue-based reference model.
module tb_ram_fifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  int checks = 0;
  int errors = 0;

  ram_fifo_ctrl_if #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) bus ();

  ram_fifo_ctrl #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .bus   (bus)
  );

  always #5 in_clk = ~in_clk;

  // Dual-port RAM stand-in: synchronous write on A, registered read on B.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge in_clk) begin
    if (bus.out_ram_wr_a) mem[bus.out_ram_addr_a] <= bus.out_ram_data_a;
    bus.in_ram_data_b <= mem[bus.out_ram_addr_b];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step(input bit p, input bit q, input logic [DW-1:0] d);
    bus.in_push = p;
    bus.in_pop  = q;
    bus.in_data = d;
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_push = 1'b0;
    bus.in_pop  = 1'b0;
    in_rst = 1'b1;
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  typedef struct {
    bit            push;
    bit            pop;
    logic [DW-1:0] data;
    bit            e_valid;
    bit            chk_data;
    logic [DW-1:0] e_data;
    int            e_level;
    bit            e_full;
    bit            e_ovf;
    bit            e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit p, bit q, logic [DW-1:0] d, bit v, bit cd,
                              logic [DW-1:0] ed, int lvl, bit f, bit o, bit u);
    vec_t t;
    t.push = p; t.pop = q; t.data = d; t.e_valid = v; t.chk_data = cd;
    t.e_data = ed; t.e_level = lvl; t.e_full = f; t.e_ovf = o; t.e_unf = u;
    vecs.push_back(t);
  endfunction

  // Reference model: all held words in order; how many are still in RAM;
  // how many have left the RAM; whether the newest of those is still in flight.
  logic [DW-1:0] m_q[$];
  int m_ram_n;
  int m_npost;
  bit m_inflight;
  bit m_ovf;
  bit m_unf;

  function automatic bit m_valid();
    return (m_npost - int'(m_inflight)) > 0;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_ram_n = 0; m_npost = 0; m_inflight = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic void m_edge(bit p, bit q, logic [DW-1:0] d);
    bit v;
    bit pa;
    bit wa;
    bit iss;
    logic [DW-1:0] dummy;
    v   = m_valid();
    pa  = q && v;
    wa  = p && (m_ram_n < DEPTH);
    iss = (m_ram_n > 0) && ((m_npost - int'(pa)) < 2);
    m_ovf = p && !wa;
    m_unf = q && !v;
    if (pa) begin dummy = m_q.pop_front(); m_npost--; end
    if (iss) begin m_ram_n--; m_npost++; end
    m_inflight = iss;
    if (wa) begin m_q.push_back(d); m_ram_n++; end
  endfunction

  initial begin
    int nout;
    int first_c;
    int last_c;
    int bubbles;
    bit p;
    bit q;
    logic [DW-1:0] d;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus.in_push = 1'b0;
    bus.in_pop  = 1'b0;
    bus.in_data = '0;
    bus.in_ram_data_b = '0;
    #1;
    @(posedge in_clk);
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_full", int'(bus.out_full), 0);
    chk("rst_level", int'(bus.out_level), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_ovf", int'(bus.out_overflow), 0);
    chk("rst_unf", int'(bus.out_underflow), 0);
    in_rst = 1'b0;

    // Vector table: single word latency, fill to full, overflow, drain, underflow.
    add(1, 0, 8'hAA, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'hAA, 1, 0, 0, 0);
    add(0, 1, 8'h00, 0, 1, 8'hAA, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 1, 8'hAA, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 1, 8'hAA, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 0, 8'h01, 0, 0, 8'h00, 2, 0, 0, 0);
    add(1, 0, 8'h02, 1, 1, 8'h00, 3, 0, 0, 0);
    add(1, 0, 8'h03, 1, 1, 8'h00, 4, 0, 0, 0);
    add(1, 0, 8'h04, 1, 1, 8'h00, 5, 0, 0, 0);
    add(1, 0, 8'h05, 1, 1, 8'h00, 6, 1, 0, 0);
    add(1, 0, 8'h06, 1, 1, 8'h00, 6, 1, 1, 0);
    add(1, 1, 8'h07, 1, 1, 8'h01, 5, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h01, 5, 0, 0, 0);
    add(0, 1, 8'h00, 1, 1, 8'h02, 4, 0, 0, 0);
    add(0, 1, 8'h00, 1, 1, 8'h03, 3, 0, 0, 0);
    add(0, 1, 8'h00, 1, 1, 8'h04, 2, 0, 0, 0);
    add(0, 1, 8'h00, 1, 1, 8'h05, 1, 0, 0, 0);
    add(0, 1, 8'h00, 0, 1, 8'h05, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 1, 8'h05, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 1, 8'h05, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].data);
      chk($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(vecs[i].e_valid));
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_data", i), int'(bus.out_data), int'(vecs[i].e_data));
      chk($sformatf("vec%0d_level", i), int'(bus.out_level), vecs[i].e_level);
      chk($sformatf("vec%0d_full", i), int'(bus.out_full), int'(vecs[i].e_full));
      chk($sformatf("vec%0d_ovf", i), int'(bus.out_overflow), int'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_unf", i), int'(bus.out_underflow), int'(vecs[i].e_unf));
    end

    // Continuous push 0..31 with pop held: in order, no bubbles, pointers wrap.
    do_reset();
    nout = 0; first_c = -1; last_c = -1; bubbles = 0;
    for (int c = 0; c < 80 && nout < 32; c++) begin
      if (bus.out_valid) begin
        chk($sformatf("wrap_data%0d", nout), int'(bus.out_data), nout);
        if (first_c < 0) first_c = c;
        last_c = c;
        nout++;
      end else if (nout > 0) begin
        bubbles++;
      end
      step(c < 32, 1'b1, DW'(c));
    end
    chk("wrap_count", nout, 32);
    chk("wrap_bubbles", bubbles, 0);
    chk("wrap_span", last_c - first_c, 31);
    chk("wrap_first", first_c, 3);
    chk("wrap_addr_a", int'(bus.out_ram_addr_a), 0);
    chk("wrap_addr_b", int'(bus.out_ram_addr_b), 0);
    step(0, 0, 0);
    chk("wrap_level", int'(bus.out_level), 0);

    // Asynchronous reset with a read in flight.
    do_reset();
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    chk("mid_level", int'(bus.out_level), 3);
    chk("mid_valid", int'(bus.out_valid), 1);
    bus.in_push = 1'b1;
    bus.in_data = 8'h44;
    in_rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_level", int'(bus.out_level), 0);
    chk("arst_full", int'(bus.out_full), 0);
    chk("arst_data", int'(bus.out_data), 0);
    chk("arst_wr_a", int'(bus.out_ram_wr_a), 0);
    chk("arst_addr_b", int'(bus.out_ram_addr_b), 0);
    bus.in_push = 1'b0;
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    step(1, 0, 8'h5A);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("post_rst_valid", int'(bus.out_valid), 1);
    chk("post_rst_data", int'(bus.out_data), 8'h5A);
    chk("post_rst_level", int'(bus.out_level), 1);

    // Random traffic against the reference model.
    do_reset();
    m_reset();
    for (int c = 0; c < 800; c++) begin
      if (c < 400) begin
        p = ($urandom_range(99) < 70);
        q = ($urandom_range(99) < 35);
      end else begin
        p = ($urandom_range(99) < 35);
        q = ($urandom_range(99) < 70);
      end
      d = DW'($urandom);
      m_edge(p, q, d);
      step(p, q, d);
      chk("rnd_valid", int'(bus.out_valid), int'(m_valid()));
      if (m_valid()) chk("rnd_data", int'(bus.out_data), int'(m_q[0]));
      chk("rnd_level", int'(bus.out_level), m_q.size());
      chk("rnd_full", int'(bus.out_full), int'(m_ram_n == DEPTH));
      chk("rnd_ovf", int'(bus.out_overflow), int'(m_ovf));
      chk("rnd_unf", int'(bus.out_underflow), int'(m_unf));
      chk("rnd_wr_b", int'(bus.out_ram_wr_b), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
